// File: rtl/key_router_pkg.sv
// Shared definitions for the key packet router.
//   state_t       : controller FSM states
//   SETTLE_CYCLES : cycles spent in SETTLE before collecting bits
//   DEF_*         : default parameter values for the router and its buffers
package key_router_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    COLLECT  = 2'd2,
    DISPATCH = 2'd3
  } state_t;

  localparam int SETTLE_CYCLES = 3;

  localparam int DEF_CH_BITS  = 2;
  localparam int DEF_PAY_W    = 2;
  localparam int DEF_DEPTH    = 6;
  localparam int DEF_OVF_MODE = 0;

endpackage

// File: rtl/key_chan_buf.sv
// One per-channel shift buffer of DEPTH entries, each {payload, valid}.
// Slot 0 is the oldest entry; occupied slots are contiguous from slot 0 and
// unoccupied slots always read zero.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push      : write {payload,1} this cycle
//   pop       : remove slot 0 this cycle (ignored when empty)
//   payload   : payload for push
//   slots     : flattened slots, slot s at [s*EW +: EW]
//   count     : occupancy
//   ovf       : high in a cycle where a push meets a full buffer
module key_chan_buf
  import key_router_pkg::*;
#(
  parameter  int PAY_W    = DEF_PAY_W,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int OVF_MODE = DEF_OVF_MODE,
  localparam int EW       = PAY_W + 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [PAY_W-1:0]    payload,
  output logic [DEPTH*EW-1:0] slots,
  output logic [CW-1:0]       count,
  output logic                ovf
);

  logic [EW-1:0] mem   [DEPTH];
  logic [EW-1:0] mem_p [DEPTH];
  logic [EW-1:0] mem_n [DEPTH];
  logic [CW-1:0] cnt_p;
  logic [CW-1:0] cnt_n;
  logic          do_pop;

  // Pop is resolved first, then the push sees the post-pop image. A push
  // that coincides with a pop therefore never finds the buffer full.
  always_comb begin
    do_pop = pop && (count != '0);
    for (int i = 0; i < DEPTH; i++) mem_p[i] = mem[i];
    cnt_p = count;
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_p[i] = mem[i+1];
      mem_p[DEPTH-1] = '0;
      cnt_p = count - CW'(1);
    end

    for (int i = 0; i < DEPTH; i++) mem_n[i] = mem_p[i];
    cnt_n = cnt_p;
    ovf   = 1'b0;
    if (push) begin
      if (cnt_p == CW'(DEPTH)) begin
        ovf = 1'b1;
        if (OVF_MODE == 0) begin
          // Evict the oldest entry to make room at the top.
          for (int i = 0; i < DEPTH - 1; i++) mem_n[i] = mem_p[i+1];
          mem_n[DEPTH-1] = {payload, 1'b1};
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cnt_p == CW'(i)) mem_n[i] = {payload, 1'b1};
        end
        cnt_n = cnt_p + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_n[i];
      count <= cnt_n;
    end
  end

  for (genvar s = 0; s < DEPTH; s++) begin : g_slot
    assign slots[s*EW +: EW] = mem[s];
  end

endmodule

// File: rtl/key_packet_router.sv
// Assembles words from two push-buttons (key0 = bit 0, key1 = bit 1, MSB
// first) and routes each word's payload into the channel buffer selected by
// its upper CH_BITS bits.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : level enable for word entry
//   key0, key1 : active-low debounced buttons
//   pop        : per-channel read strobes
//   buf_o      : flattened buffers, channel c slot s at [(c*DEPTH+s)*EW +: EW]
//   count_o    : per-channel occupancy, channel c at [c*CW +: CW]
//   word_o     : last dispatched word; word_vld pulses for one cycle with it
//   drop_cnt   : saturating count of overflow events
//   busy       : high whenever the FSM is not IDLE
//   fsm_state  : current FSM state for observation
module key_packet_router
  import key_router_pkg::*;
#(
  parameter  int CH_BITS  = DEF_CH_BITS,
  parameter  int PAY_W    = DEF_PAY_W,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int OVF_MODE = DEF_OVF_MODE,
  localparam int NCH      = 2 ** CH_BITS,
  localparam int WORD_W   = CH_BITS + PAY_W,
  localparam int EW       = PAY_W + 1,
  localparam int CW       = $clog2(DEPTH + 1),
  localparam int BW       = $clog2(WORD_W + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    key0,
  input  logic                    key1,
  input  logic [NCH-1:0]          pop,
  output logic [NCH*DEPTH*EW-1:0] buf_o,
  output logic [NCH*CW-1:0]       count_o,
  output logic [WORD_W-1:0]       word_o,
  output logic                    word_vld,
  output logic [15:0]             drop_cnt,
  output logic                    busy,
  output state_t                  fsm_state
);

  state_t              state;
  logic [1:0]          settle_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [WORD_W-1:0]   word;
  logic                key0_q;
  logic                key1_q;
  logic                press0;
  logic                press1;
  logic                one_press;
  logic                push_any;
  logic [CH_BITS-1:0]  ch;
  logic [NCH-1:0]      ovf_vec;

  // A press is a high-to-low step of the registered key; a simultaneous
  // press of both keys is ambiguous and is discarded.
  assign press0    = key0_q & ~key0;
  assign press1    = key1_q & ~key1;
  assign one_press = press0 ^ press1;

  assign push_any  = (state == DISPATCH);
  assign ch        = word[WORD_W-1:PAY_W];
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      bit_cnt    <= '0;
      word       <= '0;
      word_o     <= '0;
      word_vld   <= 1'b0;
      drop_cnt   <= '0;
      key0_q     <= 1'b1;
      key1_q     <= 1'b1;
    end else begin
      key0_q   <= key0;
      key1_q   <= key1;
      word_vld <= 1'b0;
      if (|ovf_vec && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;

      case (state)
        IDLE: begin
          bit_cnt    <= '0;
          word       <= '0;
          settle_cnt <= '0;
          if (start) state <= SETTLE;
        end
        SETTLE: begin
          if (!start) begin
            state <= IDLE;
          end else if (settle_cnt == 2'(SETTLE_CYCLES - 1)) begin
            state      <= COLLECT;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 2'd1;
          end
        end
        COLLECT: begin
          if (!start) begin
            state   <= IDLE;
            bit_cnt <= '0;
            word    <= '0;
          end else if (one_press) begin
            word    <= {word[WORD_W-2:0], press1};
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == BW'(WORD_W - 1)) state <= DISPATCH;
          end
        end
        DISPATCH: begin
          // The push into the selected channel happens on this same edge.
          word_o   <= word;
          word_vld <= 1'b1;
          bit_cnt  <= '0;
          state    <= start ? COLLECT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DEPTH*EW-1:0] slots;
    logic [CW-1:0]       cnt;

    key_chan_buf #(
      .PAY_W    (PAY_W),
      .DEPTH    (DEPTH),
      .OVF_MODE (OVF_MODE)
    ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .push    (push_any && (ch == CH_BITS'(c))),
      .pop     (pop[c]),
      .payload (word[PAY_W-1:0]),
      .slots   (slots),
      .count   (cnt),
      .ovf     (ovf_vec[c])
    );

    assign buf_o[c*DEPTH*EW +: DEPTH*EW] = slots;
    assign count_o[c*CW +: CW]           = cnt;
  end

endmodule

// File: doc/key_packet_router.md
KEY_PACKET_ROUTER -- requirements
Module: key_packet_router

Interface
REQ-001 Parameter CH_BITS, default 2, channel-select bits; NCH = 2**CH_BITS channels.
REQ-002 Parameter PAY_W, default 2, payload bits per word; WORD_W = CH_BITS+PAY_W; entry width EW = PAY_W+1.
REQ-003 Parameter DEPTH, default 6, entries per channel buffer (legal 2..16).
REQ-004 Parameter OVF_MODE, default 0, full policy: 0 = evict oldest, 1 = drop newest.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  level; 1 enables word entry.
REQ-008 key0 / key1  in  1 each  active-low buttons, debounced and synchronous to clk upstream; key0 press = bit 0, key1 press = bit 1.
REQ-009 pop  in  NCH  per-channel read strobe, one entry removed per cycle asserted.
REQ-010 buf_o  out  NCH*DEPTH*EW  flattened buffers; channel c slot s at bits [(c*DEPTH+s)*EW +: EW]; entry = {payload, valid}.
REQ-011 count_o  out  NCH*$clog2(DEPTH+1)  occupancy per channel, same packing order.
REQ-012 word_o  out  WORD_W  last assembled word; word_vld  out  1  one-cycle pulse on dispatch.
REQ-013 drop_cnt  out  16  total overflow events, saturating at 16'hFFFF.
REQ-014 busy  out  1  high when state is not IDLE.

Function
REQ-015 FSM states IDLE, SETTLE, COLLECT, DISPATCH.
REQ-016 IDLE -> SETTLE when start=1; SETTLE holds exactly 3 cycles, then COLLECT; start=0 in SETTLE or COLLECT -> IDLE, discarding partial bits.
REQ-017 Press = key registered high last cycle and low this cycle; exactly one key press per cycle accepted; simultaneous press of both keys ignored, no bit recorded.
REQ-018 Bits shift in MSB-first; after WORD_W accepted bits go to DISPATCH for one cycle.
REQ-019 DISPATCH: word_o <= word, word_vld=1, push payload word[PAY_W-1:0] into channel word[WORD_W-1:PAY_W]; next state COLLECT if start=1 else IDLE; bit counter cleared.
REQ-020 Buffer ordering: slot 0 oldest; occupied slots contiguous from 0; unoccupied slots read all-zero.
REQ-021 Push, not full: entry {payload,1} written at slot count, count+1.
REQ-022 Push, full, OVF_MODE=0: slots shift down one, new entry at DEPTH-1, count unchanged, drop_cnt+1.
REQ-023 Push, full, OVF_MODE=1: buffer unchanged, drop_cnt+1.
REQ-024 Pop, non-empty: slot 0 removed, others shift down, top slot zeroed, count-1; pop on empty ignored.
REQ-025 Push and pop same channel same cycle: pop applied first, then push; count unchanged; never counted as overflow, even when full.
REQ-026 Pops on other channels act independently in the same cycle.
REQ-027 Key presses in DISPATCH or SETTLE ignored.

Reset
REQ-028 rst=1 forces IDLE, all buffer slots 0, counts 0, word_o 0, word_vld 0, drop_cnt 0, bit counter 0, key history registers 1, immediately and regardless of clock.
REQ-029 Reset mid-word or mid-dispatch discards the word; no push occurs.

Structure
REQ-030 Package key_router_pkg holds FSM state enum, SETTLE_CYCLES=3, default parameter values.
REQ-031 One sub-module key_chan_buf (one DEPTH x EW buffer with push/pop/occupancy/overflow flag), instantiated NCH times via generate.

Verification
REQ-032 Defaults, start=1, presses 0,1,1,0 -> word_vld pulse, word_o=4'b0110, channel 1 slot 0 = 3'b101, count 1.
REQ-033 Six words to channel 0 then 7th (payload 2'b11), OVF_MODE=0 -> slot 5 = 3'b111, former slot 1 now slot 0, drop_cnt=1; OVF_MODE=1 -> buffer unchanged, drop_cnt=1.
REQ-034 Channel 2 full, pop asserted in DISPATCH cycle of new word -> count stays 6, new entry at slot 5, drop_cnt=0.
REQ-035 Both keys pressed same cycle during COLLECT -> bit count unchanged; start dropped after 2 bits -> IDLE, no push.
REQ-036 rst pulsed asynchronously between clock edges with buffers populated -> all outputs zero before next rising edge.
REQ-037 CH_BITS=3, PAY_W=4, DEPTH=4: word 7'b1011010 -> channel 5 slot 0 = 5'b10101.
